// File: rtl/rtc_field_writer.sv
// rtc_field_writer: range-checks one edited RTC field, converts it to packed
// BCD and drives a single address/data write cycle on the RTC's multiplexed
// parallel bus. The bus is only driven while a write is in flight.
//
//   state     | meaning
//   ----------+-----------------------------------------------
//   IDLE      | bus released, waiting for wr_req
//   A_SETUP   | register address on bus, ad_n low, strobe high
//   A_STROBE  | address latched by RTC, wr_n low
//   A_HOLD    | address held after strobe rises
//   D_SETUP   | BCD data on bus, ad_n high, strobe high
//   D_STROBE  | data written, wr_n low
//   D_HOLD    | data held after strobe rises
//   RELEASE   | bus tristated, chip select still low
module rtc_field_writer #(
  parameter int PHASE_CYC = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_req,
  input  logic [1:0] mode,
  input  logic [1:0] sel,
  input  logic [5:0] value,
  output logic [7:0] ad_out,
  output logic       ad_oe,
  output logic       cs_n,
  output logic       ad_n,
  output logic       wr_n,
  output logic       rd_n,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam int CW = (PHASE_CYC > 1) ? $clog2(PHASE_CYC) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(PHASE_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_A_SETUP,
    S_A_STROBE,
    S_A_HOLD,
    S_D_SETUP,
    S_D_STROBE,
    S_D_HOLD,
    S_RELEASE
  } state_t;

  state_t          r_state;
  state_t          w_nxt_state;
  logic [CW-1:0]   r_cnt;
  logic [CW-1:0]   w_nxt_cnt;
  logic [7:0]      r_addr;
  logic [7:0]      r_data;

  logic [7:0]      w_addr;
  logic [5:0]      w_lo;
  logic [5:0]      w_hi;
  logic            w_field_ok;
  logic            w_valid;
  logic [2:0]      w_tens;
  logic [5:0]      w_tens_x10;
  logic [3:0]      w_units;
  logic [7:0]      w_data;
  logic            w_accept;
  logic            w_reject;
  logic            w_done_nxt;

  logic [7:0]      w_nxt_ad;
  logic            w_nxt_oe;
  logic            w_nxt_cs_n;
  logic            w_nxt_ad_n;
  logic            w_nxt_wr_n;

  // Field map: register address and legal range for each mode/sel pair.
  always_comb begin
    w_addr     = 8'h00;
    w_lo       = 6'd0;
    w_hi       = 6'd0;
    w_field_ok = 1'b1;
    case (mode)
      2'b01: begin
        case (sel)
          2'd0:    begin w_addr = 8'h24; w_lo = 6'd1; w_hi = 6'd31; end
          2'd1:    begin w_addr = 8'h25; w_lo = 6'd1; w_hi = 6'd12; end
          2'd2:    begin w_addr = 8'h26; w_lo = 6'd0; w_hi = 6'd63; end
          default: w_field_ok = 1'b0;
        endcase
      end
      2'b10: begin
        case (sel)
          2'd0:    begin w_addr = 8'h23; w_hi = 6'd23; end
          2'd1:    begin w_addr = 8'h22; w_hi = 6'd59; end
          2'd2:    begin w_addr = 8'h21; w_hi = 6'd59; end
          default: w_field_ok = 1'b0;
        endcase
      end
      2'b11: begin
        case (sel)
          2'd0:    begin w_addr = 8'h43; w_hi = 6'd23; end
          2'd1:    begin w_addr = 8'h42; w_hi = 6'd59; end
          2'd2:    begin w_addr = 8'h41; w_hi = 6'd59; end
          default: w_field_ok = 1'b0;
        endcase
      end
      default: w_field_ok = 1'b0;
    endcase
  end

  assign w_valid = w_field_ok && (value >= w_lo) && (value <= w_hi);

  // Binary to packed BCD; a compare chain is enough since values stop at 63.
  always_comb begin
    w_tens     = 3'd0;
    w_tens_x10 = 6'd0;
    if (value >= 6'd60)      begin w_tens = 3'd6; w_tens_x10 = 6'd60; end
    else if (value >= 6'd50) begin w_tens = 3'd5; w_tens_x10 = 6'd50; end
    else if (value >= 6'd40) begin w_tens = 3'd4; w_tens_x10 = 6'd40; end
    else if (value >= 6'd30) begin w_tens = 3'd3; w_tens_x10 = 6'd30; end
    else if (value >= 6'd20) begin w_tens = 3'd2; w_tens_x10 = 6'd20; end
    else if (value >= 6'd10) begin w_tens = 3'd1; w_tens_x10 = 6'd10; end
  end

  assign w_units  = 4'(value - w_tens_x10);
  assign w_data   = {1'b0, w_tens, w_units};
  assign w_accept = (r_state == S_IDLE) && wr_req && w_valid;
  assign w_reject = (r_state == S_IDLE) && wr_req && !w_valid;

  // Next-state and phase down-counter: each bus phase ends at terminal count 0.
  always_comb begin
    w_nxt_state = r_state;
    w_nxt_cnt   = r_cnt;
    w_done_nxt  = 1'b0;
    if (r_state == S_IDLE) begin
      if (w_accept) begin
        w_nxt_state = S_A_SETUP;
        w_nxt_cnt   = CNT_LOAD;
      end
    end else if (r_cnt == '0) begin
      w_nxt_cnt = CNT_LOAD;
      case (r_state)
        S_A_SETUP:  w_nxt_state = S_A_STROBE;
        S_A_STROBE: w_nxt_state = S_A_HOLD;
        S_A_HOLD:   w_nxt_state = S_D_SETUP;
        S_D_SETUP:  w_nxt_state = S_D_STROBE;
        S_D_STROBE: w_nxt_state = S_D_HOLD;
        S_D_HOLD:   w_nxt_state = S_RELEASE;
        default: begin
          w_nxt_state = S_IDLE;
          w_nxt_cnt   = '0;
          w_done_nxt  = 1'b1;
        end
      endcase
    end else begin
      w_nxt_cnt = r_cnt - 1'b1;
    end
  end

  // Bus values for the state being entered, so the pins come straight from flops.
  always_comb begin
    w_nxt_ad   = 8'h00;
    w_nxt_oe   = 1'b0;
    w_nxt_cs_n = 1'b1;
    w_nxt_ad_n = 1'b1;
    w_nxt_wr_n = 1'b1;
    case (w_nxt_state)
      S_A_SETUP, S_A_STROBE, S_A_HOLD: begin
        w_nxt_ad   = w_accept ? w_addr : r_addr;
        w_nxt_oe   = 1'b1;
        w_nxt_cs_n = 1'b0;
        w_nxt_ad_n = 1'b0;
        w_nxt_wr_n = (w_nxt_state != S_A_STROBE);
      end
      S_D_SETUP, S_D_STROBE, S_D_HOLD: begin
        w_nxt_ad   = r_data;
        w_nxt_oe   = 1'b1;
        w_nxt_cs_n = 1'b0;
        w_nxt_wr_n = (w_nxt_state != S_D_STROBE);
      end
      S_RELEASE: w_nxt_cs_n = 1'b0;
      default: ;
    endcase
  end

  // State register and phase counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_nxt_state;
      r_cnt   <= w_nxt_cnt;
    end
  end

  // Capture address and BCD data on acceptance so later input edits are ignored.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_addr <= 8'h00;
      r_data <= 8'h00;
    end else if (w_accept) begin
      r_addr <= w_addr;
      r_data <= w_data;
    end
  end

  // Registered bus pins and status pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      ad_out <= 8'h00;
      ad_oe  <= 1'b0;
      cs_n   <= 1'b1;
      ad_n   <= 1'b1;
      wr_n   <= 1'b1;
      busy   <= 1'b0;
      done   <= 1'b0;
      err    <= 1'b0;
    end else begin
      ad_out <= w_nxt_ad;
      ad_oe  <= w_nxt_oe;
      cs_n   <= w_nxt_cs_n;
      ad_n   <= w_nxt_ad_n;
      wr_n   <= w_nxt_wr_n;
      busy   <= (w_nxt_state != S_IDLE);
      done   <= w_done_nxt;
      err    <= w_reject;
    end
  end

  assign rd_n = 1'b1;

endmodule

// File: tb/tb_rtc_field_writer.sv
// Directed bench for rtc_field_writer: full write cycles, rejections,
// boundary values, ignored requests, back-to-back and mid-cycle reset.
module tb_rtc_field_writer;

  localparam int P = 4;

  // Flag byte order: busy, ad_oe, cs_n, ad_n, wr_n, rd_n, done, err
  localparam logic [15:0] V_IDLE = 16'h3C00;
  localparam logic [15:0] V_DONE = 16'h3E00;
  localparam logic [15:0] V_ERR  = 16'h3D00;

  logic       clk = 1'b0;
  logic       reset;
  logic       wr_req;
  logic [1:0] mode;
  logic [1:0] sel;
  logic [5:0] value;
  logic [7:0] ad_out;
  logic       ad_oe, cs_n, ad_n, wr_n, rd_n, busy, done, err;
  logic [15:0] obs;

  int checks = 0;
  int errors = 0;

  rtc_field_writer #(.PHASE_CYC(P)) dut (
    .clk(clk), .reset(reset), .wr_req(wr_req), .mode(mode), .sel(sel),
    .value(value), .ad_out(ad_out), .ad_oe(ad_oe), .cs_n(cs_n), .ad_n(ad_n),
    .wr_n(wr_n), .rd_n(rd_n), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  assign obs = {busy, ad_oe, cs_n, ad_n, wr_n, rd_n, done, err, ad_out};

  task automatic chk(input string tag, input logic [15:0] o, input logic [15:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s obs=%h exp=%h", tag, o, e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected pins in cycle c of a write to address a with BCD data d.
  function automatic logic [15:0] ev(int c, logic [7:0] a, logic [7:0] d);
    if (c >= 1 && c <= 7 * P) begin
      case ((c - 1) / P)
        0:       return {8'hCC, a};
        1:       return {8'hC4, a};
        2:       return {8'hCC, a};
        3:       return {8'hDC, d};
        4:       return {8'hD4, d};
        5:       return {8'hDC, d};
        default: return 16'h9C00;
      endcase
    end else if (c == 7 * P + 1) begin
      return V_DONE;
    end
    return V_IDLE;
  endfunction

  task automatic issue(input logic [1:0] m, input logic [1:0] s, input logic [5:0] v);
    mode   = m;
    sel    = s;
    value  = v;
    wr_req = 1'b1;
    tick();
    wr_req = 1'b0;
  endtask

  // Checks cycles 1..last; optionally raises a stray wr_req in cycle inj.
  task automatic run_write(input string tag, input logic [7:0] a, input logic [7:0] d,
                           input int inj, input int last);
    for (int c = 1; c <= last; c++) begin
      chk($sformatf("%s c%0d", tag, c), obs, ev(c, a, d));
      if (c == inj) begin
        value  = 6'd45;
        wr_req = 1'b1;
      end
      if (c < last) begin
        tick();
        wr_req = 1'b0;
      end
    end
  endtask

  initial begin
    reset  = 1'b1;
    wr_req = 1'b0;
    mode   = 2'b00;
    sel    = 2'd0;
    value  = 6'd0;
    repeat (3) tick();
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk($sformatf("reset_idle %0d", i), obs, V_IDLE);
    end

    issue(2'b10, 2'd1, 6'd59);
    run_write("min59", 8'h22, 8'h59, 0, 7 * P + 1);

    // Back-to-back from the done cycle; stray request at cycle 10 ignored.
    issue(2'b10, 2'd2, 6'd30);
    run_write("sec30_ign", 8'h21, 8'h30, 10, 7 * P + 1);

    issue(2'b01, 2'd1, 6'd13);
    chk("rej_month13 c1", obs, V_ERR);
    tick();
    chk("rej_month13 c2", obs, V_IDLE);

    issue(2'b00, 2'd0, 6'd5);
    chk("rej_mode0 c1", obs, V_ERR);
    tick();
    chk("rej_mode0 c2", obs, V_IDLE);

    issue(2'b10, 2'd3, 6'd5);
    chk("rej_sel3 c1", obs, V_ERR);

    // Request accepted in the err cycle.
    issue(2'b01, 2'd0, 6'd1);
    run_write("day1", 8'h24, 8'h01, 0, 7 * P + 1);

    issue(2'b01, 2'd0, 6'd31);
    run_write("day31", 8'h24, 8'h31, 0, 7 * P + 1);

    issue(2'b01, 2'd2, 6'd63);
    run_write("year63", 8'h26, 8'h63, 0, 7 * P + 1);

    issue(2'b10, 2'd0, 6'd24);
    chk("rej_hour24 c1", obs, V_ERR);
    tick();
    chk("rej_hour24 c2", obs, V_IDLE);

    issue(2'b11, 2'd2, 6'd0);
    run_write("tsec0", 8'h41, 8'h00, 0, 7 * P + 1);

    // Reset in the middle of D_STROBE.
    issue(2'b10, 2'd0, 6'd12);
    run_write("hour12", 8'h23, 8'h12, 0, 18);
    reset = 1'b1;
    tick();
    chk("midreset c19", obs, V_IDLE);
    reset = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      chk($sformatf("post_reset_nodone %0d", i), obs, V_IDLE);
    end

    issue(2'b11, 2'd1, 6'd7);
    run_write("tmin7", 8'h42, 8'h07, 0, 7 * P + 1);

    // Reset and request together: request dropped.
    reset  = 1'b1;
    mode   = 2'b10;
    sel    = 2'd1;
    value  = 6'd5;
    wr_req = 1'b1;
    tick();
    wr_req = 1'b0;
    reset  = 1'b0;
    chk("rst_req c1", obs, V_IDLE);
    tick();
    chk("rst_req c2", obs, V_IDLE);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rtc_field_writer.md
# rtc_field_writer

Write-side back end of the RTC programming path. Takes one edited field from the button front end (programming mode, field position, 6-bit binary value), range-checks it, converts it to packed BCD and runs one complete address/data write cycle on the RTC's multiplexed parallel bus. Sits between the button/edit logic and the RTC chip pins, and owns the bus only while a write is in flight.

## Interface
Parameters:
- PHASE_CYC, 4, clk cycles each bus phase is held (≥1)

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high; clock clk
- wr_req  in  1  one-cycle request to write the field described by mode/sel/value
- mode  in  2  01 date, 10 time, 11 timer; 00 invalid
- sel  in  2  field position 0/1/2; 3 invalid
- value  in  6  binary field value
- ad_out  out  8  address/data bus drive value
- ad_oe  out  1  bus output enable (tristate control lives at top level)
- cs_n  out  1  RTC chip select, active-low
- ad_n  out  1  0 = address phase, 1 = data phase
- wr_n  out  1  write strobe, active-low
- rd_n  out  1  read strobe, held 1 (write-only block)
- busy  out  1  write cycle in progress
- done  out  1  one-cycle pulse: write completed
- err  out  1  one-cycle pulse: request rejected

## Operation
- Field map (mode,sel → reg addr, legal range):
  - 01,0 day 0x24 [1..31]; 01,1 month 0x25 [1..12]; 01,2 year 0x26 [0..63]
  - 10,0 hours 0x23 [0..23]; 10,1 minutes 0x22 [0..59]; 10,2 seconds 0x21 [0..59]
  - 11,0 timer hours 0x43 [0..23]; 11,1 timer min 0x42 [0..59]; 11,2 timer sec 0x41 [0..59]
- Rejection: mode=00, sel=3, or value outside range → err pulse, no bus activity, busy stays 0.
- BCD: data = {tens[3:0], units[3:0]}, tens = value/10, units = value%10 (e.g. 59→0x59, 7→0x07, 63→0x63).
- mode/sel/value are latched when wr_req is accepted. Later input changes have no effect on the cycle in flight.
- FSM states: IDLE, A_SETUP, A_STROBE, A_HOLD, D_SETUP, D_STROBE, D_HOLD, RELEASE.
  - Every non-IDLE state lasts exactly PHASE_CYC cycles, then advances to the next in list order. RELEASE → IDLE.
- Per-state outputs (ad_oe, cs_n, ad_n, wr_n, ad_out):
  - IDLE: 0, 1, 1, 1, 0x00
  - A_SETUP: 1, 0, 0, 1, addr
  - A_STROBE: 1, 0, 0, 0, addr
  - A_HOLD: 1, 0, 0, 1, addr
  - D_SETUP: 1, 0, 1, 1, data
  - D_STROBE: 1, 0, 1, 0, data
  - D_HOLD: 1, 0, 1, 1, data
  - RELEASE: 0, 0, 1, 1, 0x00
- All bus outputs are registered and glitch-free. wr_n never falls in the same cycle that ad_n or ad_out changes.

## Timing
- Reset values: ad_out=0x00, ad_oe=0, cs_n=1, ad_n=1, wr_n=1, rd_n=1, busy=0, done=0, err=0. FSM goes to IDLE and the phase counter clears.
- Cycle numbering: cycle 0 is the edge where wr_req=1 is sampled in IDLE.
  - Valid request: busy=1 and A_SETUP outputs from cycle 1. Phase k (k=0..6) occupies cycles kP+1..(k+1)P, with P=PHASE_CYC.
  - Cycle 7P+1: IDLE outputs, busy=0, done=1 for one cycle.
  - A new wr_req is accepted in that same cycle 7P+1.
  - Invalid request: err=1 in cycle 1 only, all else idle. A new request is accepted in cycle 1.
- wr_req while busy=1 is ignored: no queueing, no err.
- done and err are never asserted together.
- Reset mid-cycle (any state): the next edge forces reset values, the strobe is aborted, and no done is issued.
- Reset and wr_req in the same cycle: reset wins and the request is dropped.

## Test plan
- Reset release, 10 idle cycles → every output at its reset value, rd_n=1 throughout.
- PHASE_CYC=4, wr_req with mode=10, sel=1, value=59:
  - ad_out=0x22 with ad_n=0 for cycles 1–12; wr_n=0 on cycles 5–8.
  - ad_out=0x59 with ad_n=1 for cycles 13–24; wr_n=0 on cycles 17–20.
  - cs_n=0 for cycles 1–28; done on cycle 29.
- Rejections:
  - mode=01, sel=1, value=13 → err on cycle 1 only, cs_n stays 1.
  - mode=00, sel=0, value=5 → err.
  - mode=10, sel=3, value=5 → err.
- Boundary values:
  - day=1 → 0x01 to 0x24; day=31 → 0x31; year=63 → 0x63 to 0x26.
  - hours=24 → err; timer sec=0 → 0x00 to 0x41.
- Second wr_req at cycle 10 of a write with different value → ignored, original data still sent.
- Back-to-back: new wr_req at cycle 29 → accepted, cs_n stays high for that one cycle.
- Reset asserted at cycle 18 (mid D_STROBE) → cycle 19 all outputs at reset values, no done.
- Follow-up write after that reset → completes normally.
